api_rx_parser: RTL and testbench
================================

Name: api_rx_parser

Overview:
- Downstream consumer of the API controller's receive FIFO.
- Reads 11-word result blocks. Word 10 of each block carries tag 0x12 in bits [15:8] and the 0-based channel index in bits [5:0].
- Validates framing, buffers one block and presents it word-by-word on a valid/ready stream to the CPU-side result path, carrying the channel index.
- Detects lost framing, resynchronises on the tag word, and maintains good/drop block counters.

Parameters:
- BLOCK_LEN, 11, words per result block; the tag word is index BLOCK_LEN-1.
- TAG, 8'h12, marker expected in bits [15:8] of the tag word.
- CH_W, 6, channel index width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- en  in  1  parser enable; 0 = finish current activity, then hold in IDLE without reading
- rx_fifo_empty  in  1  receive FIFO empty
- rx_fifo_rd_en  out  1  receive FIFO read strobe
- rx_fifo_dout  in  32  receive FIFO data, valid the cycle after rd_en (standard, non-FWFT)
- res_vld  out  1  result word valid
- res_rdy  in  1  downstream accepts the word when res_vld && res_rdy
- res_dat  out  32  result word
- res_last  out  1  high on word BLOCK_LEN-1 of a block
- res_ch  out  CH_W  channel index of the block being emitted
- clr_cnt  in  1  synchronous clear of both counters
- good_cnt  out  16  blocks emitted, saturating
- drop_cnt  out  16  blocks/words discarded by resync, saturating
- sync_lost  out  1  high while in RESYNC

Behaviour:
- Reset values: rx_fifo_rd_en=0, res_vld=0, res_last=0, res_dat=0, res_ch=0, good_cnt=0, drop_cnt=0, sync_lost=0, state=IDLE, all word counters 0.
- Read rules:
  - rx_fifo_rd_en is asserted only when ~rx_fifo_empty, and at most one read is outstanding.
  - Each returned word is captured one cycle after its rd_en.
  - Throughput: one word per 2 cycles is acceptable.
- FSM states: IDLE, FILL, CHECK, EMIT, RESYNC.
- IDLE -> FILL when en && ~rx_fifo_empty; wr_idx is cleared to 0.
- FILL:
  - Issues reads and stores word k into buf[k]; wr_idx increments on each capture.
  - After capturing index BLOCK_LEN-1 -> CHECK.
  - An empty FIFO stalls FILL indefinitely; there is no timeout.
- CHECK, one cycle:
  - If buf[BLOCK_LEN-1][15:8]==TAG: latch res_ch=buf[10][CH_W-1:0], clear rd_idx -> EMIT.
  - Otherwise drop_cnt+1 and set sync_lost -> RESYNC.
- EMIT:
  - res_vld=1, res_dat=buf[rd_idx], res_last=(rd_idx==BLOCK_LEN-1).
  - Output holds stable while ~res_rdy.
  - On handshake rd_idx+1. On the handshake of the last word: good_cnt+1, then IDLE if ~en or FIFO empty, else FILL directly.
  - No FIFO reads occur during EMIT; a single block buffer is sufficient.
- RESYNC:
  - Reads and discards words one at a time; drop_cnt+1 per discarded word.
  - When a captured word has [15:8]==TAG, that word is also discarded, sync_lost clears and the state goes to IDLE. The next word is treated as word 0 of a block.
- Counters:
  - Saturate at 16'hFFFF.
  - clr_cnt has priority over an increment in the same cycle.
- en deassert: honoured only at IDLE entry; a block in FILL/EMIT or a resync completes normally.
- Reset mid-block: the partial block is abandoned. The FIFO is flushed externally by the same rst.
- Tag check uses bits [15:8] only; bits [7:6] and [31:16] of the tag word pass through unmodified in res_dat.

Decomposition:
- Shared package/include: TAG value, BLOCK_LEN, CH_W and the FSM state encodings, placed alongside the existing API defines so api_ctrl and api_rx_parser agree on the tag byte.
- One natural sub-module, api_sat_cnt: 16-bit saturating counter with inc and clr inputs, instantiated twice.
- The block buffer stays inline as an 11x32 register array.

Test Plan:
- Good block: push 11 words 0x100..0x109 plus tag word 0xABCD1203 -> 11 handshakes with res_ch=3, res_last only on 0xABCD1203, good_cnt=1, drop_cnt=0.
- Backpressure: same block with res_rdy toggling 1-0-0-1 -> res_dat stable across stalls, no word lost or duplicated, and no rx_fifo_rd_en during EMIT.
- Bad tag: word 10 = 0x00003405, then 3 filler words, then 0x00001200, then a good block for ch 1 -> drop_cnt=5 (1 block + 4 words), sync_lost high until the 0x1200 word, then the good block emitted with res_ch=1.
- Starved FIFO: deliver words with 5-cycle gaps of empty -> rd_en never asserted while empty, block emitted intact.
- Back-to-back: 3 good blocks for ch 0,1,2 pre-loaded, res_rdy=1 -> 33 words in order, good_cnt=3, en=0 mid-block-2 still completes block 2 and then stops before block 3.
- Counters: force good_cnt to 0xFFFF via 65535 blocks (or a forced start value), one more block -> stays 0xFFFF; clr_cnt coincident with an increment -> 0.

Source files
------------

// File: rtl/api_rx_parser_pkg.sv
// Shared constants for the API receive path.
// Holds the result block geometry, the tag byte that marks the last word of a block,
// the channel index width and the parser FSM state encodings, so that api_ctrl and
// api_rx_parser agree on the framing.
package api_rx_parser_pkg;

   localparam int unsigned BLOCK_LEN = 11;
   localparam logic [7:0]  TAG       = 8'h12;
   localparam int unsigned CH_W      = 6;
   localparam int unsigned IDX_W     = $clog2(BLOCK_LEN);

   localparam logic [2:0] StIdle   = 3'd0;
   localparam logic [2:0] StFill   = 3'd1;
   localparam logic [2:0] StCheck  = 3'd2;
   localparam logic [2:0] StEmit   = 3'd3;
   localparam logic [2:0] StResync = 3'd4;

   // The tag byte sits in bits [15:8]; every other bit of the word is payload.
   function automatic logic is_tag(input logic [31:0] word);
      return word[15:8] == TAG;
   endfunction

endpackage

// File: rtl/api_sat_cnt.sv
// Saturating up-counter with synchronous clear.
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   inc       count up by one unless already at all-ones
//   clr       synchronous clear, wins over inc
//   cnt       current count
module api_sat_cnt #(
   parameter int unsigned Width = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [Width-1:0] cnt
);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (inc && (cnt != '1)) begin
         cnt <= cnt + Width'(1);
      end
   end

endmodule

// File: rtl/api_rx_parser.sv
// Receive-FIFO result block parser.
// Reads BLOCK_LEN-word blocks from a standard (non-FWFT) FIFO, checks the tag byte in the
// last word, buffers the block and replays it on a valid/ready stream with the channel
// index taken from the tag word. On a bad tag it discards words until a tag word is seen.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   en                        parser enable, sampled only when leaving EMIT or in IDLE
//   rx_fifo_empty/rd_en/dout  FIFO read side; dout is valid the cycle after rd_en
//   res_vld/rdy/dat/last/ch   result stream; last marks the tag word, ch the channel
//   clr_cnt                   clears good_cnt and drop_cnt
//   good_cnt, drop_cnt        saturating block/word statistics
//   sync_lost                 high while searching for the next tag word
module api_rx_parser
   import api_rx_parser_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic            rx_fifo_empty,
   output logic            rx_fifo_rd_en,
   input  logic [31:0]     rx_fifo_dout,
   output logic            res_vld,
   input  logic            res_rdy,
   output logic [31:0]     res_dat,
   output logic            res_last,
   output logic [CH_W-1:0] res_ch,
   input  logic            clr_cnt,
   output logic [15:0]     good_cnt,
   output logic [15:0]     drop_cnt,
   output logic            sync_lost
);

   logic [2:0]       state_q, state_d;
   logic             rd_pend_q;
   logic [IDX_W-1:0] wr_idx_q, rd_idx_q;
   logic [CH_W-1:0]  ch_q;
   logic [31:0]      blk_q [BLOCK_LEN];

   logic rd_issue;
   logic hs;
   logic wr_last;
   logic rd_last;
   logic good_inc;
   logic drop_inc;

   localparam logic [IDX_W-1:0] LastIdx = IDX_W'(BLOCK_LEN - 1);

   assign hs      = res_vld && res_rdy;
   assign wr_last = (wr_idx_q == LastIdx);
   assign rd_last = (rd_idx_q == LastIdx);

   // One read in flight at a time: a new read is only issued once the previous word has
   // been captured, giving one word every two cycles at best.
   assign rd_issue = ((state_q == StFill) || (state_q == StResync)) &&
                     !rx_fifo_empty && !rd_pend_q;

   always_comb begin
      state_d  = state_q;
      good_inc = 1'b0;
      drop_inc = 1'b0;
      case (state_q)
         StIdle: begin
            if (en && !rx_fifo_empty) state_d = StFill;
         end
         StFill: begin
            if (rd_pend_q && wr_last) state_d = StCheck;
         end
         StCheck: begin
            if (is_tag(blk_q[BLOCK_LEN-1])) begin
               state_d = StEmit;
            end else begin
               drop_inc = 1'b1;
               state_d  = StResync;
            end
         end
         StEmit: begin
            if (hs && rd_last) begin
               good_inc = 1'b1;
               state_d  = (en && !rx_fifo_empty) ? StFill : StIdle;
            end
         end
         StResync: begin
            if (rd_pend_q) begin
               drop_inc = 1'b1;
               // The tag word closes the broken block; the next word starts a new one.
               if (is_tag(rx_fifo_dout)) state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         rd_pend_q <= 1'b0;
         wr_idx_q  <= '0;
         rd_idx_q  <= '0;
         ch_q      <= '0;
      end else begin
         state_q   <= state_d;
         rd_pend_q <= rd_issue;
         if ((state_q == StFill) && rd_pend_q) begin
            wr_idx_q <= wr_idx_q + IDX_W'(1);
         end else if ((state_d == StFill) && (state_q != StFill)) begin
            wr_idx_q <= '0;
         end
         if ((state_q == StCheck) && is_tag(blk_q[BLOCK_LEN-1])) begin
            rd_idx_q <= '0;
            ch_q     <= blk_q[BLOCK_LEN-1][CH_W-1:0];
         end else if ((state_q == StEmit) && hs) begin
            rd_idx_q <= rd_idx_q + IDX_W'(1);
         end
      end
   end

   // Block buffer is pure datapath; it is always fully rewritten before it is read.
   always_ff @(posedge clk) begin
      if ((state_q == StFill) && rd_pend_q) begin
         blk_q[wr_idx_q] <= rx_fifo_dout;
      end
   end

   assign rx_fifo_rd_en = rd_issue;
   assign res_vld       = (state_q == StEmit);
   assign res_dat       = res_vld ? blk_q[rd_idx_q] : 32'h0;
   assign res_last      = res_vld && rd_last;
   assign res_ch        = ch_q;
   assign sync_lost     = (state_q == StResync);

   api_sat_cnt #(
      .Width(16)
   ) u_good_cnt (
      .clk(clk),
      .rst(rst),
      .inc(good_inc),
      .clr(clr_cnt),
      .cnt(good_cnt)
   );

   api_sat_cnt #(
      .Width(16)
   ) u_drop_cnt (
      .clk(clk),
      .rst(rst),
      .inc(drop_inc),
      .clr(clr_cnt),
      .cnt(drop_cnt)
   );

endmodule

// File: tb/tb_api_rx_parser.sv
// Self-checking bench for api_rx_parser: FIFO model, random backpressure and a
// stream-level reference model that frames words into blocks.
module tb_api_rx_parser;
   import api_rx_parser_pkg::*;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            en = 1'b0;
   logic            rx_fifo_empty = 1'b1;
   logic            rx_fifo_rd_en;
   logic [31:0]     rx_fifo_dout = 32'h0;
   logic            res_vld;
   logic            res_rdy = 1'b1;
   logic [31:0]     res_dat;
   logic            res_last;
   logic [CH_W-1:0] res_ch;
   logic            clr_cnt = 1'b0;
   logic [15:0]     good_cnt;
   logic [15:0]     drop_cnt;
   logic            sync_lost;

   logic       sat_rst = 1'b1;
   logic       sat_inc = 1'b0;
   logic       sat_clr = 1'b0;
   logic [3:0] sat_cnt;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   api_rx_parser dut (
      .clk(clk),
      .rst(rst),
      .en(en),
      .rx_fifo_empty(rx_fifo_empty),
      .rx_fifo_rd_en(rx_fifo_rd_en),
      .rx_fifo_dout(rx_fifo_dout),
      .res_vld(res_vld),
      .res_rdy(res_rdy),
      .res_dat(res_dat),
      .res_last(res_last),
      .res_ch(res_ch),
      .clr_cnt(clr_cnt),
      .good_cnt(good_cnt),
      .drop_cnt(drop_cnt),
      .sync_lost(sync_lost)
   );

   api_sat_cnt #(
      .Width(4)
   ) u_sat (
      .clk(clk),
      .rst(sat_rst),
      .inc(sat_inc),
      .clr(sat_clr),
      .cnt(sat_cnt)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // ---------------- FIFO model (standard read latency, optional starvation gaps)
   logic [31:0] fifo_q[$];
   bit          starve = 1'b0;
   int          gap_cnt = 0;

   always @(posedge clk) begin
      int gap_n;
      gap_n = (gap_cnt > 0) ? gap_cnt - 1 : 0;
      if (rx_fifo_rd_en && (fifo_q.size() > 0)) begin
         rx_fifo_dout <= fifo_q.pop_front();
         if (starve) gap_n = 5;
      end
      gap_cnt       <= gap_n;
      rx_fifo_empty <= (fifo_q.size() == 0) || (gap_n > 0);
   end

   // ---------------- res_rdy driver: 0 = always, 1 = random, 2 = 1-0-0-1 pattern
   int rdy_mode = 0;
   int rdy_step = 0;

   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         1: res_rdy = 1'($urandom_range(0, 1));
         2: begin
            res_rdy  = ((rdy_step % 4) == 0) || ((rdy_step % 4) == 3);
            rdy_step = rdy_step + 1;
         end
         default: res_rdy = 1'b1;
      endcase
   end

   // ---------------- reference model: frames the pushed word stream into blocks
   logic [31:0] m_part[$];
   bit          m_resync = 1'b0;
   int          m_good = 0;
   int          m_drop = 0;
   logic [31:0] exp_dat[$];
   logic        exp_last[$];
   logic [31:0] exp_ch[$];

   function automatic int sat16(input int v);
      return (v >= 65535) ? 65535 : v + 1;
   endfunction

   task automatic model_word(input logic [31:0] w);
      if (m_resync) begin
         m_drop = sat16(m_drop);
         if (w[15:8] == 8'h12) m_resync = 1'b0;
      end else begin
         m_part.push_back(w);
         if (m_part.size() == 11) begin
            if (w[15:8] == 8'h12) begin
               for (int i = 0; i < 11; i++) begin
                  exp_dat.push_back(m_part[i]);
                  exp_last.push_back(i == 10);
                  exp_ch.push_back({26'h0, w[5:0]});
               end
               m_good = sat16(m_good);
            end else begin
               m_drop   = sat16(m_drop);
               m_resync = 1'b1;
            end
            m_part.delete();
         end
      end
   endtask

   task automatic push(input logic [31:0] w, input bit to_model);
      fifo_q.push_back(w);
      if (to_model) model_word(w);
   endtask

   task automatic push_good(input logic [5:0] ch, input bit to_model);
      logic [31:0] t;
      for (int i = 0; i < 10; i++) push($urandom, to_model);
      t = $urandom;
      t[15:8] = 8'h12;
      t[5:0]  = ch;
      push(t, to_model);
   endtask

   // ---------------- monitor
   int          hs_cnt = 0;
   int          viol_empty = 0;
   int          viol_emit = 0;
   int          viol_pend = 0;
   bit          rd_prev = 1'b0;
   bit          hold_chk = 1'b0;
   logic [31:0] hold_dat;
   logic        hold_last;

   always @(negedge clk) begin
      if (!rst) begin
         if (rx_fifo_rd_en && rx_fifo_empty) viol_empty++;
         if (rx_fifo_rd_en && res_vld) viol_emit++;
         if (rx_fifo_rd_en && rd_prev) viol_pend++;
         rd_prev = rx_fifo_rd_en;
         if (hold_chk) begin
            check("hold_vld", {31'h0, res_vld}, 32'h1);
            check("hold_dat", res_dat, hold_dat);
            check("hold_last", {31'h0, res_last}, {31'h0, hold_last});
         end
         hold_chk  = res_vld && !res_rdy;
         hold_dat  = res_dat;
         hold_last = res_last;
         if (res_vld && res_rdy) begin
            hs_cnt++;
            check("exp_avail", {31'h0, exp_dat.size() > 0}, 32'h1);
            if (exp_dat.size() > 0) begin
               check("res_dat", res_dat, exp_dat.pop_front());
               check("res_last", {31'h0, res_last}, {31'h0, exp_last.pop_front()});
               check("res_ch", {26'h0, res_ch}, exp_ch.pop_front());
            end
         end
      end
   end

   task automatic drain(input int budget);
      int n = 0;
      while (((exp_dat.size() != 0) || (fifo_q.size() != 0) || res_vld) && (n < budget)) begin
         @(negedge clk);
         n++;
      end
      check("drain_done", {31'h0, n < budget}, 32'h1);
      repeat (6) @(negedge clk);
   endtask

   task automatic check_counters(input string tag);
      check({tag, "_good"}, {16'h0, good_cnt}, 32'(m_good));
      check({tag, "_drop"}, {16'h0, drop_cnt}, 32'(m_drop));
   endtask

   initial begin
      int base;
      int n;
      logic [31:0] w;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_rd_en", {31'h0, rx_fifo_rd_en}, 32'h0);
      check("rst_vld", {31'h0, res_vld}, 32'h0);
      check("rst_last", {31'h0, res_last}, 32'h0);
      check("rst_dat", res_dat, 32'h0);
      check("rst_ch", {26'h0, res_ch}, 32'h0);
      check("rst_good", {16'h0, good_cnt}, 32'h0);
      check("rst_drop", {16'h0, drop_cnt}, 32'h0);
      check("rst_sync", {31'h0, sync_lost}, 32'h0);
      rst = 1'b0;
      en  = 1'b1;

      // Directed good block, channel 3
      for (int i = 0; i < 10; i++) push(32'h100 + i, 1'b1);
      push(32'hABCD1203, 1'b1);
      drain(2000);
      check_counters("good1");

      // Same block under a 1-0-0-1 ready pattern
      rdy_mode = 2;
      for (int i = 0; i < 10; i++) push(32'h100 + i, 1'b1);
      push(32'hABCD1203, 1'b1);
      drain(2000);
      check_counters("bp");
      rdy_mode = 0;

      // Bad tag, fillers, resync word, then a good block for channel 1
      for (int i = 0; i < 10; i++) push(32'h200 + i, 1'b1);
      push(32'h00003405, 1'b1);
      push(32'h0000AA01, 1'b1);
      push(32'h0000BB02, 1'b1);
      push(32'h0000CC03, 1'b1);
      n = 0;
      while ((fifo_q.size() != 0) && (n < 500)) begin
         @(negedge clk);
         n++;
      end
      repeat (6) @(negedge clk);
      check("resync_sync_lost", {31'h0, sync_lost}, 32'h1);
      check("resync_drop", {16'h0, drop_cnt}, 32'(m_drop));
      push(32'h00001200, 1'b1);
      push_good(6'd1, 1'b1);
      drain(2000);
      check("resync_cleared", {31'h0, sync_lost}, 32'h0);
      check_counters("bad");

      // Starved FIFO with random backpressure
      starve   = 1'b1;
      rdy_mode = 1;
      push_good(6'd17, 1'b1);
      drain(3000);
      starve   = 1'b0;
      check_counters("starve");

      // Back-to-back blocks, en dropped during block 2
      rdy_mode = 0;
      base = hs_cnt;
      push_good(6'd0, 1'b1);
      push_good(6'd1, 1'b1);
      push_good(6'd2, 1'b0);
      n = 0;
      while (((hs_cnt - base) < 16) && (n < 1000)) begin
         @(negedge clk);
         n++;
      end
      en = 1'b0;
      n = 0;
      while (((hs_cnt - base) < 22) && (n < 1000)) begin
         @(negedge clk);
         n++;
      end
      repeat (40) @(negedge clk);
      check("b2b_words", 32'(hs_cnt - base), 32'd22);
      check("b2b_fifo_left", 32'(fifo_q.size()), 32'd11);
      check("b2b_idle_vld", {31'h0, res_vld}, 32'h0);
      check_counters("b2b_stop");
      en = 1'b1;
      for (int i = 0; i < 11; i++) model_word(fifo_q[i]);
      drain(2000);
      check("b2b_total", 32'(hs_cnt - base), 32'd33);
      check_counters("b2b");

      // Random mix of good and broken blocks
      rdy_mode = 1;
      for (int b = 0; b < 15; b++) begin
         if ($urandom_range(0, 3) == 0) begin
            for (int i = 0; i < 10; i++) push($urandom, 1'b1);
            w = $urandom;
            if (w[15:8] == 8'h12) w[15:8] = 8'h21;
            push(w, 1'b1);
            for (int i = 0; i < int'($urandom_range(0, 4)); i++) push($urandom, 1'b1);
            w = $urandom;
            w[15:8] = 8'h12;
            push(w, 1'b1);
         end else begin
            push_good(6'($urandom), 1'b1);
         end
      end
      drain(20000);
      check_counters("rand");
      rdy_mode = 0;

      // clr_cnt coincident with the good_cnt increment
      push_good(6'd5, 1'b1);
      n = 0;
      while (!(res_vld && res_rdy && res_last) && (n < 1000)) begin
         @(negedge clk);
         n++;
      end
      clr_cnt = 1'b1;
      @(negedge clk);
      clr_cnt = 1'b0;
      m_good = 0;
      m_drop = 0;
      drain(1000);
      check_counters("clr");
      push_good(6'd6, 1'b1);
      drain(2000);
      check_counters("after_clr");

      // Saturation behaviour of the counter cell
      @(negedge clk);
      sat_rst = 1'b0;
      sat_inc = 1'b1;
      repeat (20) @(negedge clk);
      check("sat_hold", {28'h0, sat_cnt}, 32'd15);
      sat_clr = 1'b1;
      @(negedge clk);
      sat_clr = 1'b0;
      check("sat_clr_wins", {28'h0, sat_cnt}, 32'd0);
      repeat (3) @(negedge clk);
      sat_inc = 1'b0;
      check("sat_count", {28'h0, sat_cnt}, 32'd3);

      check("rd_while_empty", 32'(viol_empty), 32'd0);
      check("rd_during_emit", 32'(viol_emit), 32'd0);
      check("rd_outstanding", 32'(viol_pend), 32'd0);
      check("exp_left", 32'(exp_dat.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
